onehot_scan_encoder16: RTL and testbench

Sequential 16-to-4 encoder; the inverse of the 4-to-16 decoder. It accepts a 16-bit request or flag vector over a valid/ready handshake, then emits the 4-bit index of every set bit, one index per output handshake, in fixed priority order. It sits between decoded per-line flag sources (interrupt lines, select lines, status bits) and logic that consumes binary indices.

---
 rtl/onehot_scan_encoder16.sv | 103 ++++++++++
 tb/tb_onehot_scan_encoder16.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_scan_encoder16.sv
// Sequential 16-to-4 encoder: accepts a flag vector, then streams the index of
// every set bit, one per output handshake, in fixed priority order.
module onehot_scan_encoder16 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic [4:0]  remaining,
    output logic        empty_err
);

    // A transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and the offered data is held until that edge.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pend;
    logic [15:0] pend_nxt;
    logic        err_nxt;

    function automatic logic [3:0] pick_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (LSB_FIRST) begin
                if (v[15 - i]) idx = 4'(15 - i);
            end else begin
                if (v[i]) idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != 16'h0000) begin
                        pend_nxt  = in_vec;
                        state_nxt = SCAN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                // out_idx always tracks pend, so it names the bit to retire.
                if (out_ready) begin
                    pend_nxt = pend & ~(16'h0001 << out_idx);
                    if (out_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Index outputs are precomputed from the next pend, so they are registers
    // and read zero whenever pend is empty (IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            remaining <= '0;
            empty_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            out_idx   <= pick_idx(pend_nxt);
            out_last  <= (popcount(pend_nxt) == 5'd1);
            remaining <= popcount(pend_nxt);
            empty_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_onehot_scan_encoder16.sv
// Bench for onehot_scan_encoder16: one LSB-first and one MSB-first instance
// share stimulus and are checked against an index-queue reference model.
module tb_onehot_scan_encoder16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_vec = '0;
    logic        out_ready = 1'b0;

    logic        l_in_ready, l_out_valid, l_out_last, l_empty_err;
    logic [3:0]  l_out_idx;
    logic [4:0]  l_remaining;
    logic        m_in_ready, m_out_valid, m_out_last, m_empty_err;
    logic [3:0]  m_out_idx;
    logic [4:0]  m_remaining;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] exp_l[$];
    logic [3:0] exp_m[$];

    onehot_scan_encoder16 #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_idx(l_out_idx), .out_last(l_out_last), .remaining(l_remaining),
        .empty_err(l_empty_err)
    );

    onehot_scan_encoder16 #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_idx(m_out_idx), .out_last(m_out_last), .remaining(m_remaining),
        .empty_err(m_empty_err)
    );

    always #5 clk = ~clk;

    // Reference model: list set-bit positions in scan order.
    task automatic build_exp(input logic [15:0] v);
        exp_l.delete();
        exp_m.delete();
        for (int i = 0; i < 16; i++) if (v[i]) exp_l.push_back(4'(i));
        for (int i = 15; i >= 0; i--) if (v[i]) exp_m.push_back(4'(i));
    endtask

    task automatic offer(input logic [15:0] v);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
    endtask

    task automatic test_reset();
        logic [12:0] got_l, got_m;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got_l = {l_in_ready, l_out_valid, l_out_idx, l_out_last, l_remaining, l_empty_err};
        got_m = {m_in_ready, m_out_valid, m_out_idx, m_out_last, m_remaining, m_empty_err};
        n_checks++;
        if (got_l !== 13'b1_0_0000_0_00000_0) begin
            n_fail++; $display("FAIL reset_l: got %b expected %b", got_l, 13'b1_0_0000_0_00000_0);
        end
        n_checks++;
        if (got_m !== 13'b1_0_0000_0_00000_0) begin
            n_fail++; $display("FAIL reset_m: got %b expected %b", got_m, 13'b1_0_0000_0_00000_0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({l_in_ready, l_out_valid, m_in_ready, m_out_valid} !== 4'b1010) begin
            n_fail++; $display("FAIL after_reset: got %b expected 1010",
                               {l_in_ready, l_out_valid, m_in_ready, m_out_valid});
        end
    endtask

    task automatic test_stream();
        int el[4] = '{0, 5, 10, 15};
        logic [11:0] got_l, got_m, exp_lv, exp_mv;
        out_ready = 1'b1;
        offer(16'h8421);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got_l  = {l_out_valid, l_out_idx, l_out_last, l_remaining, l_in_ready};
            got_m  = {m_out_valid, m_out_idx, m_out_last, m_remaining, m_in_ready};
            exp_lv = {1'b1, 4'(el[i]), 1'(i == 3), 5'(4 - i), 1'b0};
            exp_mv = {1'b1, 4'(el[3 - i]), 1'(i == 3), 5'(4 - i), 1'b0};
            n_checks++;
            if (got_l !== exp_lv) begin
                n_fail++; $display("FAIL stream_l[%0d]: got %b expected %b", i, got_l, exp_lv);
            end
            n_checks++;
            if (got_m !== exp_mv) begin
                n_fail++; $display("FAIL stream_m[%0d]: got %b expected %b", i, got_m, exp_mv);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({l_out_valid, l_in_ready, l_remaining, l_out_idx, l_out_last, m_out_valid, m_in_ready} !== 14'b01_00000_0000_0_01) begin
            n_fail++; $display("FAIL stream_idle: got %b expected 01000000000001",
                               {l_out_valid, l_in_ready, l_remaining, l_out_idx, l_out_last, m_out_valid, m_in_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] got_l, got_m;
        out_ready = 1'b0;
        offer(16'h0006);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got_l = {l_out_valid, l_out_idx, l_out_last, l_remaining};
            got_m = {m_out_valid, m_out_idx, m_out_last, m_remaining};
            n_checks++;
            if (got_l !== {1'b1, 4'd1, 1'b0, 5'd2}) begin
                n_fail++; $display("FAIL stall_l[%0d]: got %b expected %b", i, got_l, {1'b1, 4'd1, 1'b0, 5'd2});
            end
            n_checks++;
            if (got_m !== {1'b1, 4'd2, 1'b0, 5'd2}) begin
                n_fail++; $display("FAIL stall_m[%0d]: got %b expected %b", i, got_m, {1'b1, 4'd2, 1'b0, 5'd2});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        got_l = {l_out_valid, l_out_idx, l_out_last, l_remaining};
        got_m = {m_out_valid, m_out_idx, m_out_last, m_remaining};
        n_checks++;
        if (got_l !== {1'b1, 4'd2, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL release_l: got %b expected %b", got_l, {1'b1, 4'd2, 1'b1, 5'd1});
        end
        n_checks++;
        if (got_m !== {1'b1, 4'd1, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL release_m: got %b expected %b", got_m, {1'b1, 4'd1, 1'b1, 5'd1});
        end
        @(negedge clk);
        n_checks++;
        if ({l_out_valid, l_in_ready, m_out_valid, m_in_ready} !== 4'b0101) begin
            n_fail++; $display("FAIL release_idle: got %b expected 0101",
                               {l_out_valid, l_in_ready, m_out_valid, m_in_ready});
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        offer(16'h0000);
        @(negedge clk);
        n_checks++;
        if ({l_empty_err, l_out_valid, l_in_ready, m_empty_err, m_out_valid, m_in_ready} !== 6'b101101) begin
            n_fail++; $display("FAIL zero_pulse: got %b expected 101101",
                               {l_empty_err, l_out_valid, l_in_ready, m_empty_err, m_out_valid, m_in_ready});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({l_empty_err, l_out_valid, l_in_ready, m_empty_err, m_out_valid, m_in_ready} !== 6'b001001) begin
                n_fail++; $display("FAIL zero_after[%0d]: got %b expected 001001", i,
                                   {l_empty_err, l_out_valid, l_in_ready, m_empty_err, m_out_valid, m_in_ready});
            end
        end
    endtask

    task automatic test_full();
        logic [10:0] got_l, got_m, exp_lv, exp_mv;
        out_ready = 1'b1;
        offer(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            got_l  = {l_out_valid, l_out_idx, l_out_last, l_remaining};
            got_m  = {m_out_valid, m_out_idx, m_out_last, m_remaining};
            exp_lv = {1'b1, 4'(i), 1'(i == 15), 5'(16 - i)};
            exp_mv = {1'b1, 4'(15 - i), 1'(i == 15), 5'(16 - i)};
            n_checks++;
            if (got_m !== exp_mv) begin
                n_fail++; $display("FAIL full_m[%0d]: got %b expected %b", i, got_m, exp_mv);
            end
            n_checks++;
            if (got_l !== exp_lv) begin
                n_fail++; $display("FAIL full_l[%0d]: got %b expected %b", i, got_l, exp_lv);
            end
        end
        offer(16'h8000);
        @(negedge clk);
        got_l = {l_out_valid, l_out_idx, l_out_last, l_remaining};
        got_m = {m_out_valid, m_out_idx, m_out_last, m_remaining};
        n_checks++;
        if (got_l !== {1'b1, 4'd15, 1'b1, 5'd1} || got_m !== {1'b1, 4'd15, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL single_8000: got l=%b m=%b expected %b", got_l, got_m, {1'b1, 4'd15, 1'b1, 5'd1});
        end
        @(negedge clk);
        n_checks++;
        if ({l_out_valid, m_out_valid, l_in_ready, m_in_ready} !== 4'b0011) begin
            n_fail++; $display("FAIL single_idle: got %b expected 0011",
                               {l_out_valid, m_out_valid, l_in_ready, m_in_ready});
        end
    endtask

    task automatic test_ignored();
        logic [11:0] got_l, got_m;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_vec   = 16'h0011;
        @(posedge clk); #1;
        in_vec   = 16'hFF00;
        @(negedge clk);
        got_l = {l_out_valid, l_out_idx, l_out_last, l_remaining, l_in_ready};
        got_m = {m_out_valid, m_out_idx, m_out_last, m_remaining, m_in_ready};
        n_checks++;
        if (got_l !== {1'b1, 4'd0, 1'b0, 5'd2, 1'b0} || got_m !== {1'b1, 4'd4, 1'b0, 5'd2, 1'b0}) begin
            n_fail++; $display("FAIL ignore_first: got l=%b m=%b", got_l, got_m);
        end
        in_vec = 16'($urandom);
        @(negedge clk);
        got_l = {l_out_valid, l_out_idx, l_out_last, l_remaining, l_in_ready};
        got_m = {m_out_valid, m_out_idx, m_out_last, m_remaining, m_in_ready};
        n_checks++;
        if (got_l !== {1'b1, 4'd4, 1'b1, 5'd1, 1'b0} || got_m !== {1'b1, 4'd0, 1'b1, 5'd1, 1'b0}) begin
            n_fail++; $display("FAIL ignore_second: got l=%b m=%b", got_l, got_m);
        end
        @(negedge clk);
        n_checks++;
        if ({l_out_valid, l_in_ready, m_out_valid, m_in_ready} !== 4'b0101) begin
            n_fail++; $display("FAIL ignore_ready: got %b expected 0101",
                               {l_out_valid, l_in_ready, m_out_valid, m_in_ready});
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({l_out_valid, m_out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL ignore_noaccept: got %b expected 00", {l_out_valid, m_out_valid});
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        offer(16'h00F0);
        @(negedge clk);
        n_checks++;
        if ({l_out_valid, l_out_idx, m_out_valid, m_out_idx} !== {1'b1, 4'd4, 1'b1, 4'd7}) begin
            n_fail++; $display("FAIL midrst_first: got %b expected %b",
                               {l_out_valid, l_out_idx, m_out_valid, m_out_idx}, {1'b1, 4'd4, 1'b1, 4'd7});
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({l_out_valid, l_in_ready, m_out_valid, m_in_ready} !== 4'b0101) begin
            n_fail++; $display("FAIL midrst_drop: got %b expected 0101",
                               {l_out_valid, l_in_ready, m_out_valid, m_in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({l_out_valid, l_in_ready, l_remaining, l_out_idx, m_out_valid, m_in_ready, m_remaining} !== 18'b01_00000_0000_01_00000) begin
                n_fail++; $display("FAIL midrst_after[%0d]: got %b", i,
                                   {l_out_valid, l_in_ready, l_remaining, l_out_idx, m_out_valid, m_in_ready, m_remaining});
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [15:0] v;
        logic [11:0] got_l, got_m, exp_lv, exp_mv;
        int guard;
        for (int t = 0; t < n; t++) begin
            case ($urandom_range(0, 9))
                0:       v = 16'h0000;
                1:       v = 16'h0001 << $urandom_range(0, 15);
                2:       v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            build_exp(v);
            out_ready = 1'($urandom_range(0, 1));
            offer(v);
            if (v == 16'h0000) begin
                @(negedge clk);
                n_checks++;
                if ({l_empty_err, l_out_valid, m_empty_err, m_out_valid} !== 4'b1010) begin
                    n_fail++; $display("FAIL rand_zero[%0d]: got %b expected 1010", t,
                                       {l_empty_err, l_out_valid, m_empty_err, m_out_valid});
                end
            end else begin
                guard = 0;
                while (exp_l.size() != 0 && guard < 100) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    got_l  = {l_out_valid, l_out_idx, l_out_last, l_remaining, l_empty_err};
                    got_m  = {m_out_valid, m_out_idx, m_out_last, m_remaining, m_empty_err};
                    exp_lv = {1'b1, exp_l[0], 1'(exp_l.size() == 1), 5'(exp_l.size()), 1'b0};
                    exp_mv = {1'b1, exp_m[0], 1'(exp_m.size() == 1), 5'(exp_m.size()), 1'b0};
                    n_checks++;
                    if (got_l !== exp_lv || l_in_ready !== 1'b0) begin
                        n_fail++; $display("FAIL rand_l vec=%h: got %b rdy=%b expected %b rdy=0", v, got_l, l_in_ready, exp_lv);
                    end
                    n_checks++;
                    if (got_m !== exp_mv || m_in_ready !== 1'b0) begin
                        n_fail++; $display("FAIL rand_m vec=%h: got %b rdy=%b expected %b rdy=0", v, got_m, m_in_ready, exp_mv);
                    end
                    @(posedge clk);
                    if (out_ready) begin
                        void'(exp_l.pop_front());
                        void'(exp_m.pop_front());
                    end
                    #1;
                    guard++;
                end
                n_checks++;
                if (exp_l.size() != 0) begin
                    n_fail++; $display("FAIL rand_timeout vec=%h: %0d indices left, expected 0", v, exp_l.size());
                end
                @(negedge clk);
                n_checks++;
                if ({l_out_valid, l_in_ready, l_remaining, m_out_valid, m_in_ready, m_remaining} !== 14'b01_00000_01_00000) begin
                    n_fail++; $display("FAIL rand_idle vec=%h: got %b", v,
                                       {l_out_valid, l_in_ready, l_remaining, m_out_valid, m_in_ready, m_remaining});
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_zero();
        test_full();
        test_ignored();
        test_reset_mid();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
